// File: rtl/cfg_serial_master.sv
// Bit-serial configuration bus transmitter: latches a word and register index,
// then shifts the word LSB-first under a select frame with per-register strobes.
module cfg_serial_master #(
  parameter int CFG_WIDTH = 32,
  parameter int NUM_REGS  = 4,
  parameter int ADDR_W    = 2,
  parameter int SETUP_CYC = 2,
  parameter int HIGH_CYC  = 2,
  parameter int HOLD_CYC  = 2,
  parameter int GUARD_CYC = 2
) (
  input  logic                 ps_clk,
  input  logic                 rst,
  input  logic [CFG_WIDTH-1:0] cfg_data,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  output logic                 sdata,
  output logic [NUM_REGS-1:0]  reg_clk,
  output logic                 select_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int MAX_SH  = (SETUP_CYC > HIGH_CYC) ? SETUP_CYC : HIGH_CYC;
  localparam int MAX_HG  = (HOLD_CYC > GUARD_CYC) ? HOLD_CYC : GUARD_CYC;
  localparam int MAX_CYC = (MAX_SH > MAX_HG) ? MAX_SH : MAX_HG;
  localparam int PH_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int BIT_W   = (CFG_WIDTH > 1) ? $clog2(CFG_WIDTH) : 1;

  localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(CFG_WIDTH - 1);
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_SETUP, S_HIGH, S_LOW, S_TRAIL, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [PH_W-1:0]      ph_q, ph_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [CFG_WIDTH-1:0] data_q, data_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 cfg_ready_q, cfg_ready_d;
  logic                 sdata_q, sdata_d;
  logic [NUM_REGS-1:0]  reg_clk_q, reg_clk_d;
  logic                 select_q, select_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  always_comb begin
    state_d = state_q;
    ph_d    = (ph_q == '0) ? '0 : ph_q - 1'b1;
    bit_d   = bit_q;
    data_d  = data_q;
    addr_d  = addr_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cfg_valid && cfg_ready_q) begin
          if ({1'b0, cfg_addr} >= NUM_REGS_W) begin
            err_d = 1'b1;
          end else begin
            data_d  = cfg_data;
            addr_d  = cfg_addr;
            bit_d   = '0;
            ph_d    = PH_W'(GUARD_CYC - 1);
            state_d = S_LEAD;
          end
        end
      end
      S_LEAD: if (ph_q == '0) begin
        ph_d    = PH_W'(SETUP_CYC - 1);
        state_d = S_SETUP;
      end
      S_SETUP: if (ph_q == '0) begin
        ph_d    = PH_W'(HIGH_CYC - 1);
        state_d = S_HIGH;
      end
      S_HIGH: if (ph_q == '0) begin
        ph_d    = PH_W'(HOLD_CYC - 1);
        state_d = S_LOW;
      end
      S_LOW: if (ph_q == '0) begin
        if (bit_q == LAST_BIT) begin
          ph_d    = PH_W'(GUARD_CYC - 1);
          state_d = S_TRAIL;
        end else begin
          // The word shifts right per bit so the outgoing bit is always data[0].
          bit_d   = bit_q + 1'b1;
          data_d  = data_q >> 1;
          ph_d    = PH_W'(SETUP_CYC - 1);
          state_d = S_SETUP;
        end
      end
      S_TRAIL: if (ph_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    cfg_ready_d = (state_d == S_IDLE);
    select_d    = (state_d inside {S_LEAD, S_SETUP, S_HIGH, S_LOW, S_TRAIL});
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    sdata_d     = (state_d inside {S_SETUP, S_HIGH, S_LOW}) && data_d[0];
    reg_clk_d   = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_clk_d[i] = (state_d == S_HIGH) && (addr_d == ADDR_W'(i));
    end
  end

  always_ff @(posedge ps_clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ph_q        <= '0;
      bit_q       <= '0;
      data_q      <= '0;
      addr_q      <= '0;
      cfg_ready_q <= 1'b1;
      sdata_q     <= 1'b0;
      reg_clk_q   <= '0;
      select_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      bit_q       <= bit_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      cfg_ready_q <= cfg_ready_d;
      sdata_q     <= sdata_d;
      reg_clk_q   <= reg_clk_d;
      select_q    <= select_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign sdata      = sdata_q;
  assign reg_clk    = reg_clk_q;
  assign select_out = select_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_cfg_serial_master.sv
// Directed bench for cfg_serial_master: a shift-register receiver model per strobe
// line plus timing monitors, across default, 3-register and fast 8-bit instances.
module tb_cfg_serial_master;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic [31:0] data;
  logic [1:0]  addr;
  logic        valid, ready, sd, sel, busy, done, err;
  logic [3:0]  rclk;

  cfg_serial_master u_dut (
    .ps_clk(clk), .rst(rst), .cfg_data(data), .cfg_addr(addr), .cfg_valid(valid),
    .cfg_ready(ready), .sdata(sd), .reg_clk(rclk), .select_out(sel),
    .busy(busy), .done(done), .err(err)
  );

  // Three-register instance for the bad-address case
  logic [31:0] c3_data;
  logic [1:0]  c3_addr;
  logic        c3_valid, c3_ready, c3_sd, c3_sel, c3_busy, c3_done, c3_err;
  logic [2:0]  c3_rclk;

  cfg_serial_master #(.NUM_REGS(3)) u_dut3 (
    .ps_clk(clk), .rst(rst), .cfg_data(c3_data), .cfg_addr(c3_addr), .cfg_valid(c3_valid),
    .cfg_ready(c3_ready), .sdata(c3_sd), .reg_clk(c3_rclk), .select_out(c3_sel),
    .busy(c3_busy), .done(c3_done), .err(c3_err)
  );

  // Fast 8-bit instance with single-cycle phases
  logic [7:0]  c8_data;
  logic [1:0]  c8_addr;
  logic        c8_valid, c8_ready, c8_sd, c8_sel, c8_busy, c8_done, c8_err;
  logic [3:0]  c8_rclk;

  cfg_serial_master #(.CFG_WIDTH(8), .SETUP_CYC(1), .HIGH_CYC(1), .HOLD_CYC(1), .GUARD_CYC(1)) u_dut8 (
    .ps_clk(clk), .rst(rst), .cfg_data(c8_data), .cfg_addr(c8_addr), .cfg_valid(c8_valid),
    .cfg_ready(c8_ready), .sdata(c8_sd), .reg_clk(c8_rclk), .select_out(c8_sel),
    .busy(c8_busy), .done(c8_done), .err(c8_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // Receiver model and timing monitor for the default instance
  logic [31:0] model [4];
  int          edges [4];
  int          sel_cyc, done_cnt, done_ok, setup_bad, hold_bad, hi_bad, hi_run, hl;
  int          busy_bad = 0;
  int          sd_run   = 0;
  int          st;
  int          clr_req  = 0;
  int          clr_seen = 0;
  logic        prev_sel = 1'b0;
  logic        prev_sd  = 1'b0;
  logic [3:0]  prev_rclk = '0;

  always @(negedge clk) begin
    st = (sd != prev_sd) ? 1 : sd_run + 1;
    if (clr_req != clr_seen) begin
      clr_seen  <= clr_req;
      sel_cyc   <= 0; done_cnt <= 0; done_ok <= 0;
      setup_bad <= 0; hold_bad <= 0; hi_bad  <= 0; hi_run <= 0; hl <= 0;
      for (int k = 0; k < 4; k++) begin
        edges[k] <= 0;
        model[k] <= '0;
      end
    end else begin
      if (sel) sel_cyc <= sel_cyc + 1;
      if (done) begin
        done_cnt <= done_cnt + 1;
        if (prev_sel && !sel) done_ok <= done_ok + 1;
      end
      for (int k = 0; k < 4; k++) begin
        if (rclk[k] && !prev_rclk[k]) begin
          edges[k] <= edges[k] + 1;
          model[k] <= {sd, model[k][31:1]};
          if (st < 3) setup_bad <= setup_bad + 1;
        end
      end
      if (|rclk) hi_run <= hi_run + 1;
      else if (|prev_rclk) begin
        if (hi_run != 2) hi_bad <= hi_bad + 1;
        hi_run <= 0;
      end
      if ((sd != prev_sd) && ((|rclk) || hl != 0)) hold_bad <= hold_bad + 1;
      hl <= (|rclk) ? 2 : ((hl != 0) ? hl - 1 : 0);
    end
    if (busy !== (sel | done)) busy_bad <= busy_bad + 1;
    sd_run    <= st;
    prev_sel  <= sel;
    prev_sd   <= sd;
    prev_rclk <= rclk;
  end

  task automatic clear_monitor();
    clr_req++;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Presents a request on the default instance and waits for it to be taken.
  task automatic send(input logic [31:0] d, input logic [1:0] a, input logic hold, input string tag);
    bit taken = 0;
    data  = d;
    addr  = a;
    valid = 1'b1;
    for (int i = 0; i < 400 && !taken; i++) begin
      if (ready) begin
        @(posedge clk);
        taken = 1;
      end else begin
        @(negedge clk);
      end
    end
    #1;
    if (!hold) valid = 1'b0;
    if (!taken) chk({tag, "_accept_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) chk({tag, "_done_timeout"}, 0, 1);
  endtask

  initial begin
    int         n_idle, errs, act, nrdy, scnt, rises, dcnt;
    logic       p8;
    logic [7:0] m8;
    bit         hit;

    rst = 1'b0;
    valid = 1'b0; data = '0; addr = '0;
    c3_valid = 1'b0; c3_data = '0; c3_addr = '0;
    c8_valid = 1'b0; c8_data = '0; c8_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",  32'(ready), 1);
    chk("rst_outs",   {26'd0, sel, busy, done, err, sd, 1'b0}, 0);
    chk("rst_regclk", 32'(rclk), 0);
    rst = 1'b1;

    // Write 4 to register 0
    clear_monitor();
    send(32'h4, 2'd0, 1'b0, "t1");
    wait_done("t1");
    repeat (2) @(negedge clk);
    chk("t1_model0",   model[0], 32'h4);
    chk("t1_edges0",   32'(edges[0]), 32);
    chk("t1_edges_oth", 32'(edges[1] + edges[2] + edges[3]), 0);
    chk("t1_sel_cyc",  32'(sel_cyc), 196);
    chk("t1_done_cnt", 32'(done_cnt), 1);
    chk("t1_done_pos", 32'(done_ok), 1);

    // Write A5A5_0F0F to register 2 with strobe timing checks
    clear_monitor();
    send(32'hA5A5_0F0F, 2'd2, 1'b0, "t2");
    wait_done("t2");
    repeat (2) @(negedge clk);
    chk("t2_model2",    model[2], 32'hA5A5_0F0F);
    chk("t2_edges2",    32'(edges[2]), 32);
    chk("t2_edges_oth", 32'(edges[0] + edges[1] + edges[3]), 0);
    chk("t2_high_len",  32'(hi_bad), 0);
    chk("t2_setup",     32'(setup_bad), 0);
    chk("t2_hold",      32'(hold_bad), 0);

    // Back-to-back with valid held; inputs change mid-transfer
    clear_monitor();
    send(32'h2, 2'd1, 1'b1, "t3a");
    data = 32'h7;
    addr = 2'd3;
    wait_done("t3a");
    n_idle = 0;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (sel) hit = 1;
      else if (ready) n_idle++;
    end
    valid = 1'b0;
    chk("t3_idle_gap", 32'(n_idle), 1);
    wait_done("t3b");
    repeat (2) @(negedge clk);
    chk("t3_model1", model[1], 32'h2);
    chk("t3_model3", model[3], 32'h7);
    chk("t3_edges",  32'(edges[1] + edges[3]), 64);
    chk("t3_dones",  32'(done_cnt), 2);

    // Bad address on the three-register instance
    @(negedge clk);
    c3_addr  = 2'd3;
    c3_data  = 32'hFFFF_FFFF;
    c3_valid = 1'b1;
    @(posedge clk);
    #1 c3_valid = 1'b0;
    errs = 0; act = 0; nrdy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      errs += int'(c3_err);
      if (c3_sel || (|c3_rclk) || c3_busy || c3_done) act++;
      if (!c3_ready) nrdy++;
    end
    chk("t4_err_pulses", 32'(errs), 1);
    chk("t4_activity",   32'(act), 0);
    chk("t4_ready_low",  32'(nrdy), 0);

    // Reset during the high phase of bit 10
    clear_monitor();
    send(32'hFFFF_FFFF, 2'd0, 1'b0, "t5");
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (rclk[0] && edges[0] >= 10) hit = 1;
    end
    chk("t5_reach_bit10", 32'(hit), 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("t5_regclk", 32'(rclk), 0);
    chk("t5_outs",   {27'd0, sel, sd, busy, done, 1'b0}, 0);
    chk("t5_ready",  32'(ready), 1);
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dcnt += int'(done) + int'(sel);
    end
    chk("t5_no_done", 32'(dcnt), 0);
    clear_monitor();
    send(32'h1, 2'd0, 1'b0, "t5b");
    wait_done("t5b");
    repeat (2) @(negedge clk);
    chk("t5_model0", model[0], 32'h1);
    chk("t5_edges0", 32'(edges[0]), 32);

    // Fast 8-bit instance
    @(negedge clk);
    c8_data  = 8'h81;
    c8_addr  = 2'd0;
    c8_valid = 1'b1;
    @(posedge clk);
    #1 c8_valid = 1'b0;
    scnt = 0; rises = 0; m8 = '0; p8 = 1'b0;
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      if (c8_sel) scnt++;
      if (c8_rclk[0] && !p8) begin
        rises++;
        m8 = {c8_sd, m8[7:1]};
      end
      p8 = c8_rclk[0];
      if (c8_done) hit = 1;
    end
    chk("t6_done_seen", 32'(hit), 1);
    chk("t6_sel_cyc",   32'(scnt), 26);
    chk("t6_model",     32'(m8), 32'h81);
    chk("t6_rises",     32'(rises), 8);

    chk("busy_vs_frame", 32'(busy_bad), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
